// File: rtl/fpadd_pkg.sv
// ----------------------------------------------------------------------------
// fpadd_pkg
// Shared types and constants for the same-sign FP32 add sequencer.
//   fp32_t        packed IEEE-754 single {sign, exp, frac}
//   fsm_state_e   sequencer states
//   MANT_W        mantissa width including the implicit leading 1
//   EXP_MAX       saturated (infinity) exponent
//   mant_of()     24-bit mantissa of an operand; exp==0 is treated as zero
// ----------------------------------------------------------------------------
package fpadd_pkg;

   localparam int unsigned MANT_W  = 24;
   localparam int unsigned EXP_W   = 8;
   localparam int unsigned FRAC_W  = 23;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ADD   = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } fsm_state_e;

   // Prepend the implicit 1; a zero exponent flushes the operand to zero.
   function automatic logic [MANT_W-1:0] mant_of(input fp32_t x);
      return (x.exp == 8'h00) ? '0 : {1'b1, x.frac};
   endfunction

endpackage

// File: rtl/fpadd_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// fpadd_seq_ctrl_if
// Operand-in / result-out handshake bundle for fpadd_seq_ctrl.
//   in_valid/in_ready, a, b            operand pair handshake (issue side)
//   out_valid/out_ready, result        result handshake (writeback side)
//   overflow, sign_mismatch, busy      status alongside the result
// modport slave  : the sequencer
// modport master : the issue/writeback side driving it
// ----------------------------------------------------------------------------
interface fpadd_seq_ctrl_if;
   import fpadd_pkg::*;

   logic  in_valid;
   logic  in_ready;
   fp32_t a;
   fp32_t b;
   logic  out_valid;
   logic  out_ready;
   fp32_t result;
   logic  overflow;
   logic  sign_mismatch;
   logic  busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, overflow, sign_mismatch, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, overflow, sign_mismatch, busy
   );

endinterface

// File: rtl/fpadd_align_shift.sv
// ----------------------------------------------------------------------------
// fpadd_align_shift
// Iterative right shifter with a down-counter for mantissa alignment.
// Optional feature macro: FPADD_RNE_ROUND_EN (keeps guard/round/sticky).
//   clk, reset  clock, synchronous active-high reset
//   load        capture diff and mant_in (diff >= MAX_ALIGN clears the mantissa)
//   diff        exponent difference = number of bit positions to shift
//   mant_in     unaligned smaller mantissa
//   step_en     shift by min(SHIFT_STEP, remaining) this cycle
//   mant_out    aligned mantissa (registered)
//   grs         guard/round/sticky bits (FPADD_RNE_ROUND_EN only)
//   done        registered: at most one step remains (so the current step is the last)
// ----------------------------------------------------------------------------
module fpadd_align_shift
   import fpadd_pkg::*;
#(
   parameter int unsigned SHIFT_STEP = 1,
   parameter int unsigned MAX_ALIGN  = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [7:0]        diff,
   input  logic [MANT_W-1:0] mant_in,
   input  logic              step_en,
   output logic [MANT_W-1:0] mant_out,
`ifdef FPADD_RNE_ROUND_EN
   output logic [2:0]        grs,
`endif
   output logic              done
);

   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic [MANT_W-1:0] mant_q, mant_d;
   logic              done_q, done_d;
`ifdef FPADD_RNE_ROUND_EN
   logic [2:0]        grs_q,  grs_d;
`endif

   // Load / shift-step next-state
   always_comb begin
      cnt_d  = cnt_q;
      mant_d = mant_q;
`ifdef FPADD_RNE_ROUND_EN
      grs_d  = grs_q;
`endif
      if (load) begin
         if (32'(diff) >= MAX_ALIGN) begin
            cnt_d  = '0;
            mant_d = '0;
`ifdef FPADD_RNE_ROUND_EN
            // Far below half an ulp: only the sticky bit survives.
            grs_d  = {2'b00, |mant_in};
`endif
         end else begin
            cnt_d  = diff;
            mant_d = mant_in;
`ifdef FPADD_RNE_ROUND_EN
            grs_d  = '0;
`endif
         end
      end else if (step_en && (cnt_q != '0)) begin
         // One bit at a time, stopping early when fewer than SHIFT_STEP remain.
         for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
            if (i < 32'(cnt_q)) begin
`ifdef FPADD_RNE_ROUND_EN
               grs_d = {mant_d[0], grs_d[2], grs_d[1] | grs_d[0]};
`endif
               mant_d = mant_d >> 1;
            end
         end
         cnt_d = (32'(cnt_q) <= SHIFT_STEP) ? '0 : cnt_q - CNT_W'(SHIFT_STEP);
      end
      done_d = (32'(cnt_d) <= SHIFT_STEP);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         mant_q <= '0;
         done_q <= 1'b1;
`ifdef FPADD_RNE_ROUND_EN
         grs_q  <= '0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         mant_q <= mant_d;
         done_q <= done_d;
`ifdef FPADD_RNE_ROUND_EN
         grs_q  <= grs_d;
`endif
      end
   end

   assign mant_out = mant_q;
   assign done     = done_q;
`ifdef FPADD_RNE_ROUND_EN
   assign grs      = grs_q;
`endif

endmodule

// File: rtl/fpadd_seq_ctrl.sv
// ----------------------------------------------------------------------------
// fpadd_seq_ctrl
// Multi-cycle sequencer for single-precision same-sign FP addition:
// IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE, one operation in flight.
// Optional feature macro: FPADD_RNE_ROUND_EN (round-to-nearest-even in NORM;
// undefined = truncation).
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    fpadd_seq_ctrl_if.slave: operand handshake (in_valid/in_ready, a, b),
//          result handshake (out_valid/out_ready, result), overflow,
//          sign_mismatch, busy. All bus outputs are registered.
// ----------------------------------------------------------------------------
module fpadd_seq_ctrl
   import fpadd_pkg::*;
#(
   parameter int unsigned SHIFT_STEP = 1,
   parameter int unsigned MAX_ALIGN  = 25
) (
   input  logic                  clk,
   input  logic                  reset,
   fpadd_seq_ctrl_if.slave       bus
);

   fsm_state_e        state_q, state_d;
   logic              sign_q, sign_d;
   logic [7:0]        exp_pre_q, exp_pre_d;
   logic [MANT_W-1:0] big_q, big_d;
   logic [MANT_W:0]   sum_q, sum_d;
   fp32_t             result_q, result_d;
   logic              overflow_q, overflow_d;
   logic              sign_mismatch_q, sign_mismatch_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;

   fp32_t             op_a, op_b;
   logic              alessb;
   logic [7:0]        diff;
   logic [MANT_W-1:0] mant_a, mant_b;
   logic              accept;

   logic              sh_load, sh_step, sh_done;
   logic [MANT_W-1:0] sh_mant;
`ifdef FPADD_RNE_ROUND_EN
   logic [2:0]        sh_grs;
   logic [MANT_W-1:0] rnd_mant;
   logic [MANT_W:0]   rnd_sum;
   logic              rnd_g, rnd_r, rnd_s, rnd_inc;
`endif

   logic [8:0]        norm_exp9;
   logic [FRAC_W-1:0] norm_fract;
   fp32_t             norm_res;
   logic              norm_ovf;

   // Operand decode: zero-exponent operands always lose the compare
   assign op_a   = bus.a;
   assign op_b   = bus.b;
   assign mant_a = mant_of(op_a);
   assign mant_b = mant_of(op_b);
   assign alessb = (op_a.exp < op_b.exp) || (op_a.exp == 8'h00);
   assign diff   = alessb ? (op_b.exp - op_a.exp) : (op_a.exp - op_b.exp);
   assign accept = (state_q == IDLE) && bus.in_valid && in_ready_q;

   fpadd_align_shift #(
      .SHIFT_STEP (SHIFT_STEP),
      .MAX_ALIGN  (MAX_ALIGN)
   ) u_align (
      .clk      (clk),
      .reset    (reset),
      .load     (sh_load),
      .diff     (diff),
      .mant_in  (alessb ? mant_a : mant_b),
      .step_en  (sh_step),
      .mant_out (sh_mant),
`ifdef FPADD_RNE_ROUND_EN
      .grs      (sh_grs),
`endif
      .done     (sh_done)
   );

   // Normalize (and optionally round) the registered sum
   always_comb begin
      norm_exp9  = {1'b0, exp_pre_q};
      norm_fract = '0;
      norm_ovf   = 1'b0;
`ifdef FPADD_RNE_ROUND_EN
      if (sum_q[MANT_W]) begin
         rnd_mant  = sum_q[MANT_W:1];
         rnd_g     = sum_q[0];
         rnd_r     = sh_grs[2];
         rnd_s     = sh_grs[1] | sh_grs[0];
         norm_exp9 = {1'b0, exp_pre_q} + 9'd1;
      end else begin
         rnd_mant  = sum_q[MANT_W-1:0];
         rnd_g     = sh_grs[2];
         rnd_r     = sh_grs[1];
         rnd_s     = sh_grs[0];
      end
      rnd_inc = rnd_g & (rnd_r | rnd_s | rnd_mant[0]);
      rnd_sum = {1'b0, rnd_mant} + (MANT_W+1)'(rnd_inc);
      // Rounding carry out of the mantissa re-normalizes by one more bit.
      if (rnd_sum[MANT_W]) begin
         norm_fract = rnd_sum[FRAC_W:1];
         norm_exp9  = norm_exp9 + 9'd1;
      end else begin
         norm_fract = rnd_sum[FRAC_W-1:0];
      end
`else
      if (sum_q[MANT_W]) begin
         norm_fract = sum_q[FRAC_W:1];
         norm_exp9  = {1'b0, exp_pre_q} + 9'd1;
      end else begin
         norm_fract = sum_q[FRAC_W-1:0];
      end
`endif
      if (norm_exp9 >= 9'({1'b0, EXP_MAX})) begin
         norm_res = {sign_q, EXP_MAX, 23'h0};
         norm_ovf = 1'b1;
      end else begin
         norm_res = {sign_q, norm_exp9[7:0], norm_fract};
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d         = state_q;
      sign_d          = sign_q;
      exp_pre_d       = exp_pre_q;
      big_d           = big_q;
      sum_d           = sum_q;
      result_d        = result_q;
      overflow_d      = overflow_q;
      sign_mismatch_d = sign_mismatch_q;
      sh_load         = 1'b0;
      sh_step         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (op_a.sign != op_b.sign) begin
                  state_d         = DONE;
                  sign_mismatch_d = 1'b1;
                  overflow_d      = 1'b0;
                  result_d        = '0;
               end else begin
                  sh_load   = 1'b1;
                  sign_d    = op_a.sign;
                  exp_pre_d = alessb ? op_b.exp : op_a.exp;
                  big_d     = alessb ? mant_b : mant_a;
                  // Nothing to shift (or everything shifted out): skip ALIGN.
                  state_d   = ((diff == 8'h00) || (32'(diff) >= MAX_ALIGN)) ? ADD : ALIGN;
               end
            end
         end
         ALIGN: begin
            sh_step = 1'b1;
            if (sh_done) state_d = ADD;
         end
         ADD: begin
            sum_d   = {1'b0, sh_mant} + {1'b0, big_q};
            state_d = NORM;
         end
         NORM: begin
            result_d   = norm_res;
            overflow_d = norm_ovf;
            state_d    = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d         = IDLE;
               overflow_d      = 1'b0;
               sign_mismatch_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         sign_q          <= 1'b0;
         exp_pre_q       <= '0;
         big_q           <= '0;
         sum_q           <= '0;
         result_q        <= '0;
         overflow_q      <= 1'b0;
         sign_mismatch_q <= 1'b0;
         out_valid_q     <= 1'b0;
         in_ready_q      <= 1'b1;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         sign_q          <= sign_d;
         exp_pre_q       <= exp_pre_d;
         big_q           <= big_d;
         sum_q           <= sum_d;
         result_q        <= result_d;
         overflow_q      <= overflow_d;
         sign_mismatch_q <= sign_mismatch_d;
         out_valid_q     <= out_valid_d;
         in_ready_q      <= in_ready_d;
         busy_q          <= busy_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.result        = result_q;
   assign bus.overflow      = overflow_q;
   assign bus.sign_mismatch = sign_mismatch_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fpadd_seq_ctrl
// Directed bench for fpadd_seq_ctrl (SHIFT_STEP=1, MAX_ALIGN=25, truncation
// build). Expected sums and latencies are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_fpadd_seq_ctrl;
   import fpadd_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   fpadd_seq_ctrl_if bus ();

   fpadd_seq_ctrl #(
      .SHIFT_STEP (1),
      .MAX_ALIGN  (25)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One operation: accept, measure latency, optional hold in DONE, then drain.
   task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_res, input logic exp_ovf, input logic exp_sm,
                         input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      bus.a        = va;
      bus.b        = vb;
      bus.in_valid = 1'b1;
      check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, ".result"}, bus.result, exp_res);
      check_eq({tag, ".ovf"}, 32'(bus.overflow), 32'(exp_ovf));
      check_eq({tag, ".sm"}, 32'(bus.sign_mismatch), 32'(exp_sm));
      check_eq({tag, ".busy"}, 32'(bus.busy), 32'd1);
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         check_eq({tag, ".hold_res"}, bus.result, exp_res);
         check_eq({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
         check_eq({tag, ".hold_inrdy"}, 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_eq({tag, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
      check_eq({tag, ".drain_inrdy"}, 32'(bus.in_ready), 32'd1);
      check_eq({tag, ".drain_flags"}, {30'd0, bus.overflow, bus.sign_mismatch}, 32'd0);
   endtask

   initial begin
      int seen_valid;
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst.result", bus.result, 32'h0);
      check_eq("rst.flags", {29'd0, bus.overflow, bus.sign_mismatch, bus.busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      //     tag       a             b             result        ovf   sm    lat hold
      run_op("one1",   32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 3,  0);
      run_op("half",   32'h3F800000, 32'h3F000000, 32'h3FC00000, 1'b0, 1'b0, 4,  5);
      run_op("far",    32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 1'b0, 3,  0);
      run_op("ovf",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 3,  0);
      run_op("sgn",    32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b1, 1,  2);
      run_op("d3",     32'h40400000, 32'h3E800000, 32'h40500000, 1'b0, 1'b0, 6,  0);
      run_op("carry",  32'h3FC00000, 32'h3F400000, 32'h40100000, 1'b0, 1'b0, 4,  0);
      run_op("neg",    32'hBF800000, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0, 3,  0);
      run_op("zero",   32'h00000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 3,  0);
      run_op("d24",    32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0, 27, 0);
      run_op("d25",    32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0, 1'b0, 3,  0);

      // Reset pulse while in ALIGN abandons the operation.
      @(negedge clk);
      bus.a        = 32'h3F800000;
      bus.b        = 32'h33800000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rstmid.busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      seen_valid = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen_valid++;
      end
      check_eq("rstmid.no_valid", 32'(seen_valid), 32'd0);
      check_eq("rstmid.in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("rstmid.busy_after", 32'(bus.busy), 32'd0);

      run_op("after",  32'h3F800000, 32'h3F000000, 32'h3FC00000, 1'b0, 1'b0, 4,  0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
